// File: rtl/sar_controller_param_if.sv
// Handshake/bus bundle between the SAR controller and its environment
// (comparator, CDAC switch drivers, result consumer).
interface sar_controller_param_if #(
  parameter int N_BITS = 12
);
  logic              start;
  logic              cont_mode;
  logic              comparator_out;
  logic              data_ready;
  logic              sample_en;
  logic [N_BITS-1:0] dac_code;
  logic              busy;
  logic              eoc;
  logic [N_BITS-1:0] data_out;
  logic              data_valid;
  logic              overrun;

  modport master (
    input  start, cont_mode, comparator_out, data_ready,
    output sample_en, dac_code, busy, eoc, data_out, data_valid, overrun
  );

  modport slave (
    output start, cont_mode, comparator_out, data_ready,
    input  sample_en, dac_code, busy, eoc, data_out, data_valid, overrun
  );
endinterface

// File: rtl/sar_controller_param.sv
// SAR conversion controller: sample phase, binary search, valid/ready result with overrun.
// Define SAR_AVG_EN to average 2^AVG_LOG2 consecutive conversions per published result.
module sar_controller_param #(
  parameter int N_BITS        = 12,
  parameter int SAMPLE_CYCLES = 2,
  parameter int AVG_LOG2      = 2
) (
  input  logic                   clk_sar,
  input  logic                   rst_n,
  sar_controller_param_if.master sar
);

  localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [N_BITS-1:0] MSB = {1'b1, {(N_BITS-1){1'b0}}};

  if (N_BITS < 2 || SAMPLE_CYCLES < 1 || AVG_LOG2 < 0) begin : g_bad_param
    $error("sar_controller_param: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [N_BITS-1:0] dac_q, trial_q, sar_q, data_q;
  logic              sample_en_q, busy_q, eoc_q, valid_q, ovr_q;

  logic [N_BITS-1:0] sar_d, pub_data_d;
  logic              last_d;

`ifdef SAR_AVG_EN
  logic [N_BITS+AVG_LOG2-1:0] acc_q, acc_sum_d;
  logic [AVG_LOG2-1:0]        avg_cnt_q;
`endif

  // Trial bit is kept when the comparator says Vin >= Vdac, otherwise dropped.
  assign sar_d = sar.comparator_out ? dac_q : (dac_q & ~trial_q);

  always_comb begin
`ifdef SAR_AVG_EN
    acc_sum_d  = acc_q + {{AVG_LOG2{1'b0}}, sar_q};
    last_d     = (avg_cnt_q == '1);
    pub_data_d = acc_sum_d[N_BITS+AVG_LOG2-1:AVG_LOG2];
`else
    last_d     = 1'b1;
    pub_data_d = sar_q;
`endif
  end

  always_ff @(posedge clk_sar or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dac_q       <= '0;
      trial_q     <= '0;
      sar_q       <= '0;
      data_q      <= '0;
      sample_en_q <= 1'b0;
      busy_q      <= 1'b0;
      eoc_q       <= 1'b0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef SAR_AVG_EN
      acc_q       <= '0;
      avg_cnt_q   <= '0;
`endif
    end else begin
      eoc_q <= 1'b0;
      if (valid_q && sar.data_ready) valid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (sar.start) begin
          state_q     <= SAMPLE;
          sample_en_q <= 1'b1;
          busy_q      <= 1'b1;
          cnt_q       <= '0;
          sar_q       <= '0;
          dac_q       <= '0;
        end
        SAMPLE: begin
          if (cnt_q == CW'(SAMPLE_CYCLES-1)) begin
            state_q     <= CONVERT;
            sample_en_q <= 1'b0;
            dac_q       <= MSB;
            trial_q     <= MSB;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CONVERT: begin
          sar_q <= sar_d;
          if (trial_q[0]) begin
            state_q <= DONE;
            eoc_q   <= 1'b1;
            dac_q   <= '0;
          end else begin
            dac_q   <= sar_d | (trial_q >> 1);
            trial_q <= trial_q >> 1;
          end
        end
        DONE: begin
          // A write while the consumer accepts in the same cycle is not an overrun.
          if (last_d) begin
            data_q  <= pub_data_d;
            valid_q <= 1'b1;
            if (valid_q && !sar.data_ready) ovr_q <= 1'b1;
          end
`ifdef SAR_AVG_EN
          acc_q     <= last_d ? '0 : acc_sum_d;
          avg_cnt_q <= avg_cnt_q + 1'b1;
`endif
          if (!last_d || sar.cont_mode) begin
            state_q     <= SAMPLE;
            sample_en_q <= 1'b1;
            cnt_q       <= '0;
            sar_q       <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sar.sample_en  = sample_en_q;
  assign sar.dac_code   = dac_q;
  assign sar.busy       = busy_q;
  assign sar.eoc        = eoc_q;
  assign sar.data_out   = data_q;
  assign sar.data_valid = valid_q;
  assign sar.overrun    = ovr_q;

endmodule

// File: tb/tb_sar_controller_param.sv
// Directed bench for sar_controller_param (N_BITS=12, SAMPLE_CYCLES=2) with an ideal
// comparator; the averaging scenario runs instead when SAR_AVG_EN is defined.
module tb_sar_controller_param;

  logic        clk_sar = 1'b0;
  logic        rst_n   = 1'b0;
  logic [11:0] vin     = '0;
  int          n_chk   = 0;
  int          n_fail  = 0;
  int          lat;

  sar_controller_param_if #(.N_BITS(12)) bus ();

  sar_controller_param #(.N_BITS(12), .SAMPLE_CYCLES(2), .AVG_LOG2(2)) dut (
    .clk_sar (clk_sar),
    .rst_n   (rst_n),
    .sar     (bus.master)
  );

  always #5 clk_sar = ~clk_sar;

  assign bus.comparator_out = (vin >= bus.dac_code);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge of the first SAMPLE cycle (cycle T+1).
  task automatic pulse_start();
    @(negedge clk_sar) bus.start = 1'b1;
    @(negedge clk_sar) bus.start = 1'b0;
  endtask

  task automatic wait_eoc(input int start_lat, output int l);
    l = start_lat;
    while (!bus.eoc && l < start_lat + 40) begin
      @(negedge clk_sar);
      l++;
    end
    if (!bus.eoc) chk("eoc_timeout", {31'd0, bus.eoc}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sample_en"}, {31'd0, bus.sample_en}, 32'd0);
    chk({tag, "_dac_code"}, {20'd0, bus.dac_code}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_eoc"}, {31'd0, bus.eoc}, 32'd0);
    chk({tag, "_data_out"}, {20'd0, bus.data_out}, 32'd0);
    chk({tag, "_data_valid"}, {31'd0, bus.data_valid}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, bus.overrun}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.cont_mode = 1'b0; bus.data_ready = 1'b0;
    repeat (3) @(negedge clk_sar);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk_sar);

`ifdef SAR_AVG_EN
    // Four conversions alternating 0x400/0x403 average to 0x401.
    bus.data_ready = 1'b1;
    vin = 12'h400;
    pulse_start();
    wait_eoc(1, lat);
    chk("avg_first_lat", lat, 32'd15);
    for (int i = 0; i < 4; i++) begin
      vin = (i % 2 == 0) ? 12'h403 : 12'h400;
      @(negedge clk_sar);
      chk($sformatf("avg_valid_%0d", i), {31'd0, bus.data_valid}, (i == 3) ? 32'd1 : 32'd0);
      if (i < 3) begin
        wait_eoc(1, lat);
        chk($sformatf("avg_gap_%0d", i), lat, 32'd15);
      end
    end
    chk("avg_data_out", {20'd0, bus.data_out}, 32'h401);
    chk("avg_overrun", {31'd0, bus.overrun}, 32'd0);
    repeat (20) @(negedge clk_sar);
    chk("avg_idle_busy", {31'd0, bus.busy}, 32'd0);
`else
    // 1: single conversion of 0xA5C, trace first trial codes and latency.
    vin = 12'hA5C;
    pulse_start();
    chk("t1_sample_en_c1", {31'd0, bus.sample_en}, 32'd1);
    chk("t1_busy_c1", {31'd0, bus.busy}, 32'd1);
    @(negedge clk_sar);
    chk("t1_sample_en_c2", {31'd0, bus.sample_en}, 32'd1);
    chk("t1_dac_c2", {20'd0, bus.dac_code}, 32'h000);
    @(negedge clk_sar);
    chk("t1_sample_en_c3", {31'd0, bus.sample_en}, 32'd0);
    chk("t1_dac_k0", {20'd0, bus.dac_code}, 32'h800);
    @(negedge clk_sar);
    chk("t1_dac_k1", {20'd0, bus.dac_code}, 32'hC00);
    @(negedge clk_sar);
    chk("t1_dac_k2", {20'd0, bus.dac_code}, 32'hA00);
    wait_eoc(5, lat);
    chk("t1_latency", lat, 32'd15);
    @(negedge clk_sar);
    chk("t1_eoc_pulse", {31'd0, bus.eoc}, 32'd0);
    chk("t1_data_out", {20'd0, bus.data_out}, 32'hA5C);
    chk("t1_data_valid", {31'd0, bus.data_valid}, 32'd1);
    chk("t1_busy_done", {31'd0, bus.busy}, 32'd0);
    bus.data_ready = 1'b1;
    @(negedge clk_sar);
    chk("t1_valid_cleared", {31'd0, bus.data_valid}, 32'd0);

    // 2: full-scale extremes.
    vin = 12'h000;
    pulse_start();
    wait_eoc(1, lat);
    @(negedge clk_sar);
    chk("t2_zero", {20'd0, bus.data_out}, 32'h000);
    vin = 12'hFFF;
    pulse_start();
    wait_eoc(1, lat);
    @(negedge clk_sar);
    chk("t2_full", {20'd0, bus.data_out}, 32'hFFF);

    // 3: continuous mode ramp with consumer always ready.
    repeat (2) @(negedge clk_sar);
    bus.cont_mode = 1'b1;
    vin = 12'h100;
    pulse_start();
    wait_eoc(1, lat);
    chk("t3_first_lat", lat, 32'd15);
    for (int i = 0; i < 4; i++) begin
      vin = 12'h101 + 12'(i);
      if (i == 3) bus.cont_mode = 1'b0;
      @(negedge clk_sar);
      chk($sformatf("t3_data_%0d", i), {20'd0, bus.data_out}, 32'h100 + i);
      if (i < 3) begin
        wait_eoc(1, lat);
        chk($sformatf("t3_gap_%0d", i), lat, 32'd15);
      end
    end
    chk("t3_overrun", {31'd0, bus.overrun}, 32'd0);
    repeat (3) @(negedge clk_sar);
    chk("t3_idle", {31'd0, bus.busy}, 32'd0);

    // 4: continuous mode with stalled consumer -> overrun.
    bus.data_ready = 1'b0;
    bus.cont_mode  = 1'b1;
    vin = 12'h200;
    pulse_start();
    wait_eoc(1, lat);
    vin = 12'h300;
    @(negedge clk_sar);
    chk("t4_ovr_first", {31'd0, bus.overrun}, 32'd0);
    chk("t4_data_first", {20'd0, bus.data_out}, 32'h200);
    wait_eoc(1, lat);
    bus.cont_mode = 1'b0;
    @(negedge clk_sar);
    chk("t4_ovr_set", {31'd0, bus.overrun}, 32'd1);
    chk("t4_data_newest", {20'd0, bus.data_out}, 32'h300);
    bus.data_ready = 1'b1;
    repeat (2) @(negedge clk_sar);
    chk("t4_valid_acc", {31'd0, bus.data_valid}, 32'd0);
    chk("t4_ovr_sticky", {31'd0, bus.overrun}, 32'd1);

    // 5: asynchronous reset during CONVERT step 5, then a clean conversion.
    vin = 12'h5A3;
    pulse_start();
    repeat (7) @(negedge clk_sar);
    chk("t5_pre_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async");
    @(negedge clk_sar) rst_n = 1'b1;
    repeat (3) @(negedge clk_sar);
    chk("t5_no_partial", {31'd0, bus.data_valid}, 32'd0);
    pulse_start();
    wait_eoc(1, lat);
    chk("t5_latency", lat, 32'd15);
    @(negedge clk_sar);
    chk("t5_data", {20'd0, bus.data_out}, 32'h5A3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
